// File: rtl/incubator_plant.sv
// incubator_plant: behavioural thermal model of an incubator chamber.
// A prescaler issues a tick every TICK_DIV cycles; on each tick the
// registered temperature moves by a delta chosen by the plant mode.
// Ports: clk, reset (async, active-high), heater, cooler, cooler_rps[3:0],
//   fault_clr -> sensor[7:0] (signed), tick, fault, mode[1:0].
// Build option: define PLANT_NOISE_EN to add an LFSR disturbance per tick.
module incubator_plant #(
  parameter int TICK_DIV  = 16,
  parameter int T_INIT    = 20,
  parameter int T_AMBIENT = 22,
  parameter int HEAT_STEP = 2,
  parameter int T_MIN     = -40,
  parameter int T_MAX     = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              heater,
  input  logic              cooler,
  input  logic [3:0]        cooler_rps,
  input  logic              fault_clr,
  output logic signed [7:0] sensor,
  output logic              tick,
  output logic              fault,
  output logic [1:0]        mode
);

  typedef enum logic [1:0] {
    DRIFT = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FLT   = 2'd3
  } mode_e;

  localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);
  localparam logic signed [9:0] MIN10  = 10'(T_MIN);
  localparam logic signed [9:0] MAX10  = 10'(T_MAX);
  localparam logic signed [9:0] AMB10  = 10'(T_AMBIENT);
  localparam logic signed [9:0] STEP10 = 10'(HEAT_STEP);
  localparam logic signed [7:0] INIT8  = 8'(T_INIT);

  mode_e              mode_q, mode_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [7:0]  temp_q, temp_d;
  logic signed [9:0]  temp_ext;
  logic signed [9:0]  delta;
  logic signed [9:0]  sum;
  logic [3:0]         rps_half;

  // Prescaler
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

  // Mode: decoded every cycle, FAULT held until cleared
  always_comb begin
    mode_d = DRIFT;
    unique case ({heater, cooler})
      2'b00:   mode_d = DRIFT;
      2'b10:   mode_d = HEAT;
      2'b01:   mode_d = COOL;
      default: mode_d = FLT;
    endcase
    if (mode_q == FLT && !(fault_clr && !(heater && cooler)))
      mode_d = FLT;
  end

`ifdef PLANT_NOISE_EN
  logic [7:0]        lfsr_q;
  logic              lfsr_fb;
  logic signed [9:0] dist;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    dist = 10'sd0;
    unique case (lfsr_q[1:0])
      2'b00:   dist = -10'sd1;
      2'b11:   dist = 10'sd1;
      default: dist = 10'sd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr_q <= 8'hA5;
    else if (tick)
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
`endif

  // Thermal delta, widened to 10 bits so the clamp sees true overflow
  assign temp_ext = {{2{temp_q[7]}}, temp_q};
  assign rps_half = cooler_rps >> 1;

  always_comb begin
    delta = 10'sd0;
    unique case (mode_q)
      DRIFT: begin
        if (temp_ext < AMB10)
          delta = 10'sd1;
        else if (temp_ext > AMB10)
          delta = -10'sd1;
        else
          delta = 10'sd0;
      end
      HEAT:    delta = STEP10;
      COOL:    delta = 10'sd0 - $signed({6'd0, rps_half});
      default: delta = 10'sd0;
    endcase
`ifdef PLANT_NOISE_EN
    if (mode_q != FLT)
      delta = delta + dist;
`endif
  end

  assign sum = temp_ext + delta;

  always_comb begin
    temp_d = temp_q;
    if (tick) begin
      if (sum < MIN10)
        temp_d = MIN10[7:0];
      else if (sum > MAX10)
        temp_d = MAX10[7:0];
      else
        temp_d = sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      mode_q <= DRIFT;
      temp_q <= INIT8;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      temp_q <= temp_d;
    end
  end

  assign sensor = temp_q;
  assign mode   = mode_q;
  assign fault  = (mode_q == FLT);

endmodule

// File: tb/tb_incubator_plant.sv
// tb_incubator_plant: vector table, hand sequences and random stimulus
// against a cycle-level arithmetic model of the incubator plant.
module tb_incubator_plant;

  localparam int TD = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              heater = 1'b0;
  logic              cooler = 1'b0;
  logic [3:0]        rps = 4'd0;
  logic              fault_clr = 1'b0;
  logic signed [7:0] sensor;
  logic              tick;
  logic              fault;
  logic [1:0]        mode;

  int errors = 0;
  int checks = 0;

  int m_temp = 20;
  int m_cnt  = 0;
  int m_mode = 0;
  int m_lfsr = 8'hA5;

  always #5 clk = ~clk;

  incubator_plant #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .heater(heater),
    .cooler(cooler),
    .cooler_rps(rps),
    .fault_clr(fault_clr),
    .sensor(sensor),
    .tick(tick),
    .fault(fault),
    .mode(mode)
  );

  typedef struct {
    bit h;
    bit c;
    int r;
    int ticks;
    int exp_s;
    int exp_m;
  } vec_t;

  vec_t vt[12];

  function automatic int clamp(input int v);
    if (v < -40) return -40;
    if (v > 100) return 100;
    return v;
  endfunction

  function automatic int decode(input bit h, input bit c);
    if (h && c) return 3;
    if (h) return 1;
    if (c) return 2;
    return 0;
  endfunction

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 255) | fb;
  endfunction

  function automatic int noise_of(input int l);
    if ((l & 3) == 0) return -1;
    if ((l & 3) == 3) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int d;
    if (reset) begin
      m_temp = 20;
      m_cnt  = 0;
      m_mode = 0;
      m_lfsr = 8'hA5;
    end else begin
      if (m_cnt == TD - 1) begin
        case (m_mode)
          0: d = (m_temp < 22) ? 1 : ((m_temp > 22) ? -1 : 0);
          1: d = 2;
          2: d = -(int'(rps) / 2);
          default: d = 0;
        endcase
`ifdef PLANT_NOISE_EN
        if (m_mode != 3) d = d + noise_of(m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
`endif
        m_temp = clamp(m_temp + d);
      end
      m_cnt = (m_cnt + 1) % TD;
      if (!(m_mode == 3 && !(fault_clr && !(heater && cooler))))
        m_mode = decode(heater, cooler);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge();
      check("sensor", int'(sensor), m_temp);
      check("tick", int'(tick), int'(m_cnt == TD - 1));
      check("mode", int'(mode), m_mode);
      check("fault", int'(fault), int'(m_mode == 3));
    end
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 0,  1,  21,  0};
    vt[1]  = '{1'b0, 1'b0, 0,  1,  22,  0};
    vt[2]  = '{1'b0, 1'b0, 0,  2,  22,  0};
    vt[3]  = '{1'b1, 1'b0, 0,  10, 42,  1};
    vt[4]  = '{1'b0, 1'b1, 8,  3,  30,  2};
    vt[5]  = '{1'b0, 1'b1, 6,  2,  24,  2};
    vt[6]  = '{1'b0, 1'b1, 4,  1,  22,  2};
    vt[7]  = '{1'b0, 1'b1, 1,  1,  22,  2};
    vt[8]  = '{1'b0, 1'b1, 15, 1,  15,  2};
    vt[9]  = '{1'b1, 1'b0, 0,  45, 100, 1};
    vt[10] = '{1'b0, 1'b1, 15, 25, -40, 2};
    vt[11] = '{1'b0, 1'b0, 0,  4,  -36, 0};

    // Reset state
    step(3);
    check("rst_sensor", int'(sensor), 20);
    check("rst_tick", int'(tick), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_fault", int'(fault), 0);
    reset = 1'b0;

    // Vector table, each entry ends aligned to a tick boundary
    for (int i = 0; i < 12; i++) begin
      heater = vt[i].h;
      cooler = vt[i].c;
      rps    = 4'(vt[i].r);
      step(TD * vt[i].ticks);
`ifndef PLANT_NOISE_EN
      check($sformatf("vec%0d_sensor", i), int'(sensor), vt[i].exp_s);
`endif
      check($sformatf("vec%0d_mode", i), int'(mode), vt[i].exp_m);
    end

    // Sticky fault, clear blocked while both drives high
    heater = 1'b1; cooler = 1'b1; rps = 4'd0;
    step(1);
    check("flt_mode", int'(mode), 3);
    check("flt_flag", int'(fault), 1);
    heater = 1'b0; cooler = 1'b0;
    step(7);
    check("flt_mode_held", int'(mode), 3);
`ifndef PLANT_NOISE_EN
    check("flt_frozen", int'(sensor), -36);
`endif
    heater = 1'b1; cooler = 1'b1; fault_clr = 1'b1;
    step(1);
    check("flt_clr_blocked", int'(mode), 3);
    heater = 1'b0; cooler = 1'b0;
    step(1);
    check("flt_cleared", int'(mode), 0);
    check("flt_flag_low", int'(fault), 0);
    fault_clr = 1'b0;
    step(6);
`ifndef PLANT_NOISE_EN
    check("flt_drift", int'(sensor), -34);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 150; i++) begin
      heater    = 1'($urandom_range(0, 1));
      cooler    = 1'($urandom_range(0, 1));
      rps       = 4'($urandom_range(0, 15));
      fault_clr = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 40) == 0);
      step($urandom_range(1, 6));
    end
    reset = 1'b0; heater = 1'b0; cooler = 1'b0; fault_clr = 1'b0;

    // Mid-count reset discards the partial period
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    heater = 1'b1;
    step(5 * TD);
`ifndef PLANT_NOISE_EN
    check("pre_rst_sensor", int'(sensor), 30);
`endif
    heater = 1'b0;
    step(2);
    reset = 1'b1;
    #1;
    check("async_rst_sensor", int'(sensor), 20);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_mode", int'(mode), 0);
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("rel_tick%0d", i), int'(tick), int'(i == 2));
    end
    step(1);
`ifndef PLANT_NOISE_EN
    check("rel_first_update", int'(sensor), 21);
`endif

`ifdef PLANT_NOISE_EN
    step(8 * TD);
    check("noise_range", int'(sensor >= 14 && sensor <= 30), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/incubator_plant.md
INCUBATOR_PLANT -- requirements
Module: incubator_plant

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 16: clock cycles per thermal update (legal range 2..65535).
REQ-002 The block SHALL have parameter T_INIT, default 20: signed temperature loaded at reset.
REQ-003 The block SHALL have parameter T_AMBIENT, default 22: signed ambient temperature for passive drift.
REQ-004 The block SHALL have parameter HEAT_STEP, default 2: degrees added per tick while heating.
REQ-005 The block SHALL have parameters T_MIN, default -40, and T_MAX, default 100: signed clamp limits.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port heater, input, 1 bit: heater drive from the controller.
REQ-009 The block SHALL have port cooler, input, 1 bit: cooler drive from the controller.
REQ-010 The block SHALL have port cooler_rps, input, 4 bits, unsigned: cooler speed.
REQ-011 The block SHALL have port fault_clr, input, 1 bit: synchronous clear of sticky fault.
REQ-012 The block SHALL have port sensor, output, 8 bits, signed: simulated chamber temperature, registered.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each thermal update cycle.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky flag, heater and cooler both asserted.
REQ-015 The block SHALL have port mode, output, 2 bits: plant state, 0 DRIFT, 1 HEAT, 2 COOL, 3 FAULT.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high in the cycle where count equals TICK_DIV-1.
REQ-017 Mode SHALL be updated every cycle from heater/cooler: 00 gives DRIFT, 10 gives HEAT, 01 gives COOL, 11 gives FAULT.
REQ-018 FAULT SHALL be sticky: it is left only when fault_clr is high and heater and cooler are not both high, and then goes to the mode decoded from the inputs in that cycle.
REQ-019 fault SHALL equal 1 exactly when mode is FAULT.
REQ-020 On the rising edge ending a tick cycle, sensor SHALL update from the mode held during that cycle, with latency 1 edge after the tick cycle.
REQ-021 Deltas: DRIFT moves sensor 1 toward T_AMBIENT, or 0 when equal; HEAT adds HEAT_STEP; COOL subtracts cooler_rps>>1 (rps 4 gives -2, 6 gives -3, 8 gives -4, 0 gives 0); FAULT gives 0.
REQ-022 The sum SHALL be formed in 10-bit signed arithmetic and clamped to [T_MIN, T_MAX] before it is registered; no 8-bit wrap-around is allowed.
REQ-023 Input changes in non-tick cycles SHALL update mode but SHALL NOT affect sensor until the next tick.

Reset
REQ-024 While reset is high: sensor=T_INIT, prescaler=0, tick=0, fault=0, mode=DRIFT, LFSR=8'hA5 when present.
REQ-025 Reset asserted mid-count SHALL discard the partial period; the first tick after release SHALL come TICK_DIV cycles after the first rising edge with reset low.

Configuration
REQ-026 With macro PLANT_NOISE_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance on each tick, and bits[1:0] SHALL add a disturbance to the delta before clamping: 00 gives -1, 01 or 10 gives 0, 11 gives +1. No disturbance SHALL be applied in FAULT.
REQ-027 Without PLANT_NOISE_EN, no LFSR logic SHALL exist and the behaviour SHALL be fully deterministic per REQ-021.

Verification (TICK_DIV=4, defaults otherwise, PLANT_NOISE_EN undefined unless stated)
REQ-028 Release reset, inputs 0 -> sensor 20; tick on cycles 4, 8, ...; sensor 21 then 22, then holds at 22.
REQ-029 heater=1 for 10 ticks from 22 -> sensor 42; then cooler=1, heater=0, rps=8 for 3 ticks -> sensor 30.
REQ-030 heater=1 for 45 ticks from 22 -> sensor clamps at 100 with no wrap to negative.
REQ-031 heater=cooler=1 for 1 cycle, then 00 -> fault=1, mode=3, sensor frozen; fault_clr=1 -> mode=0 on the next edge and drift resumes.
REQ-032 Reset asserted at prescaler count 2 with sensor at 30 -> sensor=20 immediately; next tick 4 cycles after release.
REQ-033 With PLANT_NOISE_EN, DRIFT at ambient for 8 ticks -> sensor stays within 22±8 and matches the reference-model LFSR sequence from seed A5.
